// File: rtl/instruction_pointer_stacked.sv
// Fetch-stage program counter with 2/4-byte stride, redirect load, stall,
// and an integrated circular return-address stack for call/return hints.
module instruction_pointer_stacked #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter logic [31:0] RESET_ADDRESS = 32'h0040_0000,
  parameter int          STACK_DEPTH   = 4
) (
  input  logic                              i_Clock,
  input  logic                              i_Reset,
  input  logic                              i_Load,
  input  logic [ADDRESS_WIDTH-1:0]          i_LoadAddress,
  input  logic                              i_Stride,
  input  logic                              i_Stall,
  input  logic                              i_Push,
  input  logic                              i_Pop,
  output logic [ADDRESS_WIDTH-1:0]          o_MemoryAddress,
  output logic [ADDRESS_WIDTH-1:0]          o_LinkAddress,
  output logic [ADDRESS_WIDTH-1:0]          o_StackTop,
  output logic [$clog2(STACK_DEPTH):0]      o_StackCount,
  output logic                              o_StackEmpty,
  output logic                              o_StackFull,
  output logic                              o_Overflow,
  output logic                              o_Underflow
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDRESS_WIDTH-1:0] RESET_PC    = ADDRESS_WIDTH'(RESET_ADDRESS);
  localparam logic [CW-1:0]            DEPTH_COUNT = CW'(STACK_DEPTH);

  logic [ADDRESS_WIDTH-1:0] pc_r;
  logic [PW-1:0]            stackPtr_r;
  logic [CW-1:0]            count_r;
  logic [ADDRESS_WIDTH-1:0] stack_r [STACK_DEPTH];
  logic                     overflow_r;
  logic                     underflow_r;

  logic [ADDRESS_WIDTH-1:0] strideAdd_s;
  logic [ADDRESS_WIDTH-1:0] link_s;
  logic [ADDRESS_WIDTH-1:0] top_s;
  logic                     empty_s;
  logic                     full_s;
  logic                     opEnable_s;

  logic [ADDRESS_WIDTH-1:0] nextPc_s;
  logic [PW-1:0]            nextPtr_s;
  logic [CW-1:0]            nextCount_s;
  logic                     writeEnable_s;
  logic [PW-1:0]            writeIndex_s;
  logic                     nextOverflow_s;
  logic                     nextUnderflow_s;

  // Stride of 4 sets bit 2, stride of 2 sets bit 1; link wraps naturally.
  assign strideAdd_s = {{(ADDRESS_WIDTH-3){1'b0}}, i_Stride, ~i_Stride, 1'b0};
  assign link_s      = pc_r + strideAdd_s;

  // Status decodes depend on registered state only.
  assign empty_s    = (count_r == {CW{1'b0}});
  assign full_s     = (count_r == DEPTH_COUNT);
  assign top_s      = empty_s ? {ADDRESS_WIDTH{1'b0}} : stack_r[stackPtr_r];
  // A redirect forces stack operations through even while stalled.
  assign opEnable_s = ~i_Stall | i_Load;

  assign o_MemoryAddress = pc_r;
  assign o_LinkAddress   = link_s;
  assign o_StackTop      = top_s;
  assign o_StackCount    = count_r;
  assign o_StackEmpty    = empty_s;
  assign o_StackFull     = full_s;
  assign o_Overflow      = overflow_r;
  assign o_Underflow     = underflow_r;

  // Next-state selection for PC, stack pointer, count and status pulses.
  always_comb begin
    nextPc_s        = pc_r;
    nextPtr_s       = stackPtr_r;
    nextCount_s     = count_r;
    writeEnable_s   = 1'b0;
    writeIndex_s    = stackPtr_r;
    nextOverflow_s  = 1'b0;
    nextUnderflow_s = 1'b0;

    if (i_Load) begin
      nextPc_s = i_LoadAddress;
    end else if (i_Pop && !empty_s && !i_Stall) begin
      nextPc_s = top_s;
    end else if (i_Stall) begin
      nextPc_s = pc_r;
    end else begin
      nextPc_s = link_s;
    end

    if (opEnable_s) begin
      case ({i_Push, i_Pop})
        2'b11: begin
          if (empty_s) begin
            // Nothing to return to: behave as a plain push and flag the pop.
            writeEnable_s   = 1'b1;
            writeIndex_s    = stackPtr_r + PW'(1);
            nextPtr_s       = stackPtr_r + PW'(1);
            nextCount_s     = CW'(1);
            nextUnderflow_s = 1'b1;
          end else begin
            // Tail call: replace the top in place.
            writeEnable_s = 1'b1;
            writeIndex_s  = stackPtr_r;
          end
        end
        2'b10: begin
          writeEnable_s = 1'b1;
          writeIndex_s  = stackPtr_r + PW'(1);
          nextPtr_s     = stackPtr_r + PW'(1);
          if (full_s) begin
            // Pointer wrap overwrites the oldest entry; depth is unchanged.
            nextOverflow_s = 1'b1;
          end else begin
            nextCount_s = count_r + CW'(1);
          end
        end
        2'b01: begin
          if (empty_s) begin
            nextUnderflow_s = 1'b1;
          end else begin
            nextPtr_s   = stackPtr_r - PW'(1);
            nextCount_s = count_r - CW'(1);
          end
        end
        default: begin
          nextPtr_s = stackPtr_r;
        end
      endcase
    end else begin
      nextPtr_s = stackPtr_r;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      pc_r        <= RESET_PC;
      stackPtr_r  <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      pc_r        <= nextPc_s;
      stackPtr_r  <= nextPtr_s;
      count_r     <= nextCount_s;
      overflow_r  <= nextOverflow_s;
      underflow_r <= nextUnderflow_s;
    end
  end

  // Return-address storage; contents are meaningless while count is zero.
  always_ff @(posedge i_Clock) begin
    if (writeEnable_s && !i_Reset) begin
      stack_r[writeIndex_s] <= link_s;
    end
  end

endmodule

// File: tb/tb_instruction_pointer_stacked.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_instruction_pointer_stacked;

  localparam int DEPTH = 4;

  logic        i_Clock = 1'b0;
  logic        i_Reset, i_Load, i_Stride, i_Stall, i_Push, i_Pop;
  logic [31:0] i_LoadAddress;
  logic [31:0] o_MemoryAddress, o_LinkAddress, o_StackTop;
  logic [2:0]  o_StackCount;
  logic        o_StackEmpty, o_StackFull, o_Overflow, o_Underflow;

  instruction_pointer_stacked dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Load(i_Load),
    .i_LoadAddress(i_LoadAddress), .i_Stride(i_Stride), .i_Stall(i_Stall),
    .i_Push(i_Push), .i_Pop(i_Pop),
    .o_MemoryAddress(o_MemoryAddress), .o_LinkAddress(o_LinkAddress),
    .o_StackTop(o_StackTop), .o_StackCount(o_StackCount),
    .o_StackEmpty(o_StackEmpty), .o_StackFull(o_StackFull),
    .o_Overflow(o_Overflow), .o_Underflow(o_Underflow)
  );

  always #5 i_Clock = ~i_Clock;

  int total = 0;
  int bad   = 0;

  // Reference model: PC plus a queue whose back is the top of stack.
  logic [31:0] mPc;
  logic [31:0] mStk[$];
  logic        mOvf, mUnf;

  typedef struct {
    logic        ld;
    logic [31:0] addr;
    logic        st;
    logic        stall;
    logic        push;
    logic        pop;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic [31:0] top;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic ld, input logic [31:0] addr, input logic st,
                              input logic stall, input logic push, input logic pop,
                              input logic [31:0] pc, input logic [2:0] cnt,
                              input logic [31:0] top, input logic ovf, input logic unf);
    vec_t v;
    v.ld = ld; v.addr = addr; v.st = st; v.stall = stall; v.push = push; v.pop = pop;
    v.pc = pc; v.cnt = cnt; v.top = top; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    logic [31:0] t;
    t = (mStk.size() > 0) ? mStk[mStk.size()-1] : 32'h0;
    chk("pc",    o_MemoryAddress, mPc);
    chk("top",   o_StackTop, t);
    chk("count", {29'h0, o_StackCount}, 32'(mStk.size()));
    chk("empty", {31'h0, o_StackEmpty}, {31'h0, mStk.size() == 0});
    chk("full",  {31'h0, o_StackFull},  {31'h0, mStk.size() == DEPTH});
    chk("ovf",   {31'h0, o_Overflow},  {31'h0, mOvf});
    chk("unf",   {31'h0, o_Underflow}, {31'h0, mUnf});
  endtask

  task automatic doReset();
    i_Reset = 1'b1; i_Load = 1'b0; i_LoadAddress = 32'h0; i_Stride = 1'b1;
    i_Stall = 1'b0; i_Push = 1'b1; i_Pop = 1'b1;
    @(posedge i_Clock); #1;
    i_Reset = 1'b0; i_Push = 1'b0; i_Pop = 1'b0;
    mPc = 32'h0040_0000; mStk.delete(); mOvf = 1'b0; mUnf = 1'b0;
    checkModel();
  endtask

  // Apply one cycle of inputs, check link before the edge, advance model, check after.
  task automatic step(input logic ld, input logic [31:0] a, input logic st,
                      input logic stall, input logic push, input logic pop);
    logic [31:0] lnk, topv, newPc;
    int          sz;
    i_Load = ld; i_LoadAddress = a; i_Stride = st; i_Stall = stall;
    i_Push = push; i_Pop = pop;
    #1;
    lnk  = mPc + (st ? 32'd4 : 32'd2);
    chk("link", o_LinkAddress, lnk);
    sz   = mStk.size();
    topv = (sz > 0) ? mStk[sz-1] : 32'h0;
    if (ld)                            newPc = a;
    else if (pop && sz > 0 && !stall)  newPc = topv;
    else if (stall)                    newPc = mPc;
    else                               newPc = lnk;
    mOvf = 1'b0; mUnf = 1'b0;
    if (!stall || ld) begin
      if (push && pop) begin
        if (sz == 0) begin mStk.push_back(lnk); mUnf = 1'b1; end
        else mStk[sz-1] = lnk;
      end else if (push) begin
        if (sz == DEPTH) begin mStk.delete(0); mOvf = 1'b1; end
        mStk.push_back(lnk);
      end else if (pop) begin
        if (sz == 0) mUnf = 1'b1;
        else void'(mStk.pop_back());
      end
    end
    mPc = newPc;
    @(posedge i_Clock); #1;
    checkModel();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    i_Reset = 1'b1; i_Load = 1'b0; i_LoadAddress = 32'h0; i_Stride = 1'b1;
    i_Stall = 1'b0; i_Push = 1'b0; i_Pop = 1'b0;

    //           ld    addr          st    stl   psh   pop   pc            cnt   top           ovf   unf
    tbl[0]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0004, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0008, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 32'h0040_1000,1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_1000, 3'd1, 32'h0040_000C,1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_000C, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_000E, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 32'h0050_0000,1'b1, 1'b0, 1'b1, 1'b0, 32'h0050_0000, 3'd1, 32'h0040_0014,1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 32'h0060_0000,1'b1, 1'b0, 1'b1, 1'b0, 32'h0060_0000, 3'd2, 32'h0050_0004,1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 32'h0070_0000,1'b1, 1'b0, 1'b1, 1'b0, 32'h0070_0000, 3'd3, 32'h0060_0004,1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 32'h0080_0000,1'b1, 1'b0, 1'b1, 1'b0, 32'h0080_0000, 3'd4, 32'h0070_0004,1'b0, 1'b0);
    tbl[10] = mk(1'b1, 32'h0090_0000,1'b1, 1'b0, 1'b1, 1'b0, 32'h0090_0000, 3'd4, 32'h0080_0004,1'b1, 1'b0);
    tbl[11] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h0090_0000, 3'd4, 32'h0080_0004,1'b0, 1'b0);
    tbl[12] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h0090_0000, 3'd4, 32'h0080_0004,1'b0, 1'b0);
    tbl[13] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0080_0004, 3'd3, 32'h0070_0004,1'b0, 1'b0);
    tbl[14] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0070_0004, 3'd2, 32'h0060_0004,1'b0, 1'b0);
    tbl[15] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0060_0004, 3'd1, 32'h0050_0004,1'b0, 1'b0);
    tbl[16] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0050_0004, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[17] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0050_0008, 3'd0, 32'h0,        1'b0, 1'b1);
    tbl[18] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0050_000C, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[19] = mk(1'b1, 32'h00A0_0000,1'b1, 1'b0, 1'b1, 1'b0, 32'h00A0_0000, 3'd1, 32'h0050_0010,1'b0, 1'b0);
    tbl[20] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0050_0010, 3'd1, 32'h00A0_0002,1'b0, 1'b0);
    tbl[21] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h00A0_0002, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[22] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h00A0_0006, 3'd1, 32'h00A0_0006,1'b0, 1'b1);
    tbl[23] = mk(1'b1, 32'h00B0_0000,1'b1, 1'b0, 1'b0, 1'b1, 32'h00B0_0000, 3'd0, 32'h0,        1'b0, 1'b0);
    tbl[24] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h00B0_0000, 3'd0, 32'h0,        1'b0, 1'b0);

    // Reset state
    doReset();
    chk("rst_pc", o_MemoryAddress, 32'h0040_0000);
    chk("rst_top", o_StackTop, 32'h0);

    // Directed vector table
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].ld, tbl[i].addr, tbl[i].st, tbl[i].stall, tbl[i].push, tbl[i].pop);
      chk($sformatf("tbl%0d_pc", i), o_MemoryAddress, tbl[i].pc);
      chk($sformatf("tbl%0d_cnt", i), {29'h0, o_StackCount}, {29'h0, tbl[i].cnt});
      chk($sformatf("tbl%0d_top", i), o_StackTop, tbl[i].top);
      chk($sformatf("tbl%0d_full", i), {31'h0, o_StackFull}, {31'h0, tbl[i].cnt == 3'd4});
      chk($sformatf("tbl%0d_empty", i), {31'h0, o_StackEmpty}, {31'h0, tbl[i].cnt == 3'd0});
      chk($sformatf("tbl%0d_ovf", i), {31'h0, o_Overflow}, {31'h0, tbl[i].ovf});
      chk($sformatf("tbl%0d_unf", i), {31'h0, o_Underflow}, {31'h0, tbl[i].unf});
    end

    // Address wrap at the top of the address space
    step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc0", o_MemoryAddress, 32'hFFFF_FFFE);
    chk("wrap_link0", o_LinkAddress, 32'h0000_0000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc1", o_MemoryAddress, 32'h0000_0000);
    chk("wrap_link1", o_LinkAddress, 32'h0000_0002);

    // Reset mid-stream discards the stack
    step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_cnt", {29'h0, o_StackCount}, 32'd2);
    doReset();
    chk("mid_rst_pc", o_MemoryAddress, 32'h0040_0000);
    chk("mid_rst_cnt", {29'h0, o_StackCount}, 32'd0);
    chk("mid_rst_empty", {31'h0, o_StackEmpty}, 32'd1);
    chk("mid_rst_top", o_StackTop, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_rst_unf", {31'h0, o_Underflow}, 32'd1);
    chk("post_rst_pc", o_MemoryAddress, 32'h0040_0004);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(63) == 0) begin
        doReset();
      end else begin
        step($urandom_range(7) == 0, $urandom, 1'($urandom_range(1)),
             $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
